// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard, MDU and halt sequencing controller for the 5-stage pipeline
module pipe_ctrl #(
    parameter int CNT_W       = 64,
    parameter int STALL_W     = 32,
    parameter int MDU_MAX_CYC = 70
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid_i,
    input  logic [4:0]         id_rs1_i,
    input  logic [4:0]         id_rs2_i,
    input  logic               id_use_rs1_i,
    input  logic               id_use_rs2_i,
    input  logic               id_branch_i,
    input  logic               id_mdu_i,
    input  logic               id_exit_i,
    input  logic               ex_load_i,
    input  logic [4:0]         ex_rd_i,
    input  logic               mdu_done_i,
    input  logic               wb_valid_i,
    input  logic               wb_exit_i,
    output logic               pc_we_o,
    output logic               ifid_we_o,
    output logic               ifid_flush_o,
    output logic               idex_bubble_o,
    output logic               mdu_start_o,
    output logic               halt_o,
    output logic               err_o,
    output logic [1:0]         state_o,
    output logic [CNT_W-1:0]   cycle_cnt_o,
    output logic [CNT_W-1:0]   instret_o,
    output logic [STALL_W-1:0] stall_cnt_o
);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MDU_WAIT = 2'd1;
    localparam logic [1:0] DRAIN    = 2'd2;
    localparam logic [1:0] HALT     = 2'd3;
    localparam int MW = $clog2(MDU_MAX_CYC + 1);

    logic [1:0]    state_nxt;
    logic [MW-1:0] mdu_cnt;
    logic          pc_we, ifid_we, flush, bubble, start, halt;
    logic          exit_hit, load_use, mdu_to;

    assign exit_hit = id_valid_i & id_exit_i;
    assign load_use = id_valid_i & ex_load_i & (ex_rd_i != 5'd0) &
                      ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) | (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
    // timeout fires on the cycle the wait count would reach the limit; a same-cycle done wins
    assign mdu_to = (state_o == MDU_WAIT) & ~mdu_done_i & (mdu_cnt == MW'(MDU_MAX_CYC - 1));

    // per-state control decode and next-state selection
    always_comb begin
        pc_we     = 1'b0;
        ifid_we   = 1'b0;
        flush     = 1'b0;
        bubble    = 1'b0;
        start     = 1'b0;
        halt      = 1'b0;
        state_nxt = state_o;
        case (state_o)
            RUN: begin
                pc_we   = ~(exit_hit | load_use | (id_valid_i & id_mdu_i));
                ifid_we = exit_hit | ~(load_use | (id_valid_i & id_mdu_i));
                flush   = exit_hit | (~load_use & ~(id_valid_i & id_mdu_i) & id_valid_i & id_branch_i);
                bubble  = ~exit_hit & (load_use | (id_valid_i & id_mdu_i));
                start   = ~exit_hit & ~load_use & id_valid_i & id_mdu_i;
                state_nxt = exit_hit ? DRAIN : start ? MDU_WAIT : RUN;
            end
            MDU_WAIT: begin
                pc_we     = mdu_done_i;
                ifid_we   = mdu_done_i;
                bubble    = ~mdu_done_i;
                state_nxt = mdu_done_i ? RUN : mdu_to ? HALT : MDU_WAIT;
            end
            DRAIN: begin
                flush     = 1'b1;
                state_nxt = (wb_valid_i & wb_exit_i) ? HALT : DRAIN;
            end
            default: halt = 1'b1;
        endcase
    end

    // control outputs are held low while reset is asserted
    always_comb begin
        pc_we_o       = rst_n & pc_we;
        ifid_we_o     = rst_n & ifid_we;
        ifid_flush_o  = rst_n & flush;
        idex_bubble_o = rst_n & bubble;
        mdu_start_o   = rst_n & start;
        halt_o        = rst_n & halt;
    end

    // state, MDU wait counter, sticky error and performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_o     <= RUN;
            mdu_cnt     <= '0;
            err_o       <= 1'b0;
            cycle_cnt_o <= '0;
            instret_o   <= '0;
            stall_cnt_o <= '0;
        end else begin
            state_o <= state_nxt;
            mdu_cnt <= start ? '0 : (state_o == MDU_WAIT) ? mdu_cnt + 1'b1 : mdu_cnt;
            if (mdu_to) err_o <= 1'b1;
            if (state_o != HALT) cycle_cnt_o <= cycle_cnt_o + 1'b1;
            if (wb_valid_i) instret_o <= instret_o + 1'b1;
            if (!pc_we && (state_o == RUN || state_o == MDU_WAIT)) stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl with an 8-cycle MDU timeout
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs1, id_use_rs2, id_branch, id_mdu, id_exit;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_load, mdu_done, wb_valid, wb_exit;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble, mdu_start, halt, err;
    logic [1:0]  state;
    logic [63:0] cycle_cnt, instret;
    logic [31:0] stall_cnt;
    int          vectors = 0;
    int          errors  = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(64), .STALL_W(32), .MDU_MAX_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .id_branch_i(id_branch), .id_mdu_i(id_mdu), .id_exit_i(id_exit),
        .ex_load_i(ex_load), .ex_rd_i(ex_rd), .mdu_done_i(mdu_done),
        .wb_valid_i(wb_valid), .wb_exit_i(wb_exit),
        .pc_we_o(pc_we), .ifid_we_o(ifid_we), .ifid_flush_o(ifid_flush),
        .idex_bubble_o(idex_bubble), .mdu_start_o(mdu_start), .halt_o(halt),
        .err_o(err), .state_o(state), .cycle_cnt_o(cycle_cnt),
        .instret_o(instret), .stall_cnt_o(stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_branch = 0; id_mdu = 0; id_exit = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_load = 0; mdu_done = 0; wb_valid = 0; wb_exit = 0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    initial begin
        clear_in();
        rst_n = 0;
        settle();
        check("rst_pc_we", pc_we, 0);
        check("rst_ifid_we", ifid_we, 0);
        check("rst_halt", halt, 0);
        check("rst_state", state, 0);
        tick();
        tick();
        check("rst_cycle", cycle_cnt, 0);
        check("rst_err", err, 0);
        rst_n = 1;

        // load-use on rs2
        do_reset();
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 3; id_use_rs2 = 1; id_rs2 = 5; ex_load = 1; ex_rd = 5;
        settle();
        check("lu_pc_we", pc_we, 0);
        check("lu_ifid_we", ifid_we, 0);
        check("lu_bubble", idex_bubble, 1);
        check("lu_start", mdu_start, 0);
        tick();
        ex_load = 0;
        settle();
        check("lu2_pc_we", pc_we, 1);
        check("lu2_bubble", idex_bubble, 0);
        check("lu2_stall", stall_cnt, 1);
        check("lu2_cycle", cycle_cnt, 1);
        tick();

        // load to x0 never stalls
        do_reset();
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 0; ex_load = 1; ex_rd = 0;
        settle();
        check("x0_pc_we", pc_we, 1);
        check("x0_bubble", idex_bubble, 0);
        tick();
        check("x0_stall", stall_cnt, 0);

        // jalr depending on a load: stall first, then redirect
        do_reset();
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 7; id_branch = 1; ex_load = 1; ex_rd = 7;
        settle();
        check("jl_pc_we", pc_we, 0);
        check("jl_flush", ifid_flush, 0);
        check("jl_bubble", idex_bubble, 1);
        tick();
        ex_load = 0;
        settle();
        check("jl2_pc_we", pc_we, 1);
        check("jl2_flush", ifid_flush, 1);
        check("jl2_ifid_we", ifid_we, 1);
        tick();

        // MDU with done on the sixth wait cycle
        do_reset();
        id_valid = 1; id_mdu = 1;
        settle();
        check("mdu_start", mdu_start, 1);
        check("mdu_pc_we", pc_we, 0);
        check("mdu_bubble", idex_bubble, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("mdu_w_state", state, 1);
            check("mdu_w_start", mdu_start, 0);
            check("mdu_w_pc_we", pc_we, 0);
            tick();
        end
        mdu_done = 1;
        settle();
        check("mdu_d_pc_we", pc_we, 1);
        check("mdu_d_ifid_we", ifid_we, 1);
        check("mdu_d_bubble", idex_bubble, 0);
        tick();
        clear_in();
        settle();
        check("mdu_d_state", state, 0);
        check("mdu_d_stall", stall_cnt, 6);
        check("mdu_d_cycle", cycle_cnt, 7);
        check("mdu_d_err", err, 0);

        // MDU timeout after 8 wait cycles
        do_reset();
        id_valid = 1; id_mdu = 1;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("to_w_err", err, 0);
            check("to_w_state", state, 1);
            tick();
        end
        check("to_err", err, 1);
        check("to_state", state, 3);
        check("to_halt", halt, 1);
        check("to_pc_we", pc_we, 0);
        check("to_cycle", cycle_cnt, 9);
        check("to_stall", stall_cnt, 9);
        tick();
        tick();
        tick();
        check("to_cycle_frozen", cycle_cnt, 9);
        check("to_stall_frozen", stall_cnt, 9);
        check("to_state_held", state, 3);

        // EBREAK drain to halt
        do_reset();
        id_valid = 1; id_exit = 1;
        settle();
        check("ex_pc_we", pc_we, 0);
        check("ex_flush", ifid_flush, 1);
        check("ex_ifid_we", ifid_we, 1);
        tick();
        clear_in();
        wb_valid = 1;
        settle();
        check("dr1_state", state, 2);
        check("dr1_flush", ifid_flush, 1);
        check("dr1_pc_we", pc_we, 0);
        check("dr1_ifid_we", ifid_we, 0);
        tick();
        wb_valid = 0;
        settle();
        check("dr2_flush", ifid_flush, 1);
        tick();
        wb_valid = 1; wb_exit = 1;
        settle();
        check("dr3_state", state, 2);
        check("dr3_flush", ifid_flush, 1);
        tick();
        clear_in();
        settle();
        check("hl_state", state, 3);
        check("hl_halt", halt, 1);
        check("hl_flush", ifid_flush, 0);
        check("hl_instret", instret, 2);
        check("hl_cycle", cycle_cnt, 4);
        check("hl_stall", stall_cnt, 1);
        tick();
        check("hl_instret_idle", instret, 2);

        // reset asserted mid-drain
        do_reset();
        id_valid = 1; id_exit = 1;
        tick();
        clear_in();
        tick();
        check("md_state", state, 2);
        rst_n = 0;
        settle();
        check("md_rst_state", state, 0);
        check("md_rst_cycle", cycle_cnt, 0);
        check("md_rst_flush", ifid_flush, 0);
        check("md_rst_start", mdu_start, 0);
        tick();
        rst_n = 1;
        settle();
        check("md_run_pc_we", pc_we, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard/sequencing controller for the RV64IM 5-stage pipeline (IF/ID/EX/MEM/WB); branches resolve in ID.
- Decides each cycle:
  - PC advance or hold;
  - IF/ID register update or flush;
  - bubble insertion into ID/EX.
- Sequences multi-cycle MUL/DIV (MDU) operations and the EBREAK drain-to-halt.
- Keeps cycle, retired-instruction and stall counters.

Parameters:
- CNT_W, 64, width of cycle_cnt_o and instret_o.
- STALL_W, 32, width of stall_cnt_o.
- MDU_MAX_CYC, 70, cycles MDU_WAIT may last before timeout error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid_i  in  1  ID holds a valid instruction.
- id_rs1_i  in  5  ID rs1 index.
- id_rs2_i  in  5  ID rs2 index.
- id_use_rs1_i  in  1  ID instruction reads rs1.
- id_use_rs2_i  in  1  ID instruction reads rs2.
- id_branch_i  in  1  ID redirects PC (jal/jalr/taken branch).
- id_mdu_i  in  1  ID instruction is MUL/DIV class.
- id_exit_i  in  1  ID instruction is EBREAK.
- ex_load_i  in  1  EX holds a valid load.
- ex_rd_i  in  5  EX destination register.
- mdu_done_i  in  1  MDU result valid (1-cycle pulse).
- wb_valid_i  in  1  instruction retires this cycle.
- wb_exit_i  in  1  retiring instruction is EBREAK.
- pc_we_o  out  1  PC register update enable.
- ifid_we_o  out  1  IF/ID register update enable.
- ifid_flush_o  out  1  IF/ID loads a NOP bubble.
- idex_bubble_o  out  1  ID/EX loads a bubble instead of the ID result.
- mdu_start_o  out  1  MDU launch pulse.
- halt_o  out  1  core halted.
- err_o  out  1  sticky MDU timeout.
- state_o  out  2  FSM state.
- cycle_cnt_o  out  CNT_W  cycle counter.
- instret_o  out  CNT_W  retired-instruction counter.
- stall_cnt_o  out  STALL_W  stall-cycle counter.

Behaviour:
- Reset (rst_n=0, async):
  - state=RUN, all counters 0, err_o=0, MDU cycle counter 0.
  - All control outputs (pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, mdu_start_o, halt_o) forced 0 while rst_n=0.
  - Reset mid-MDU or mid-drain returns to RUN with no start pulse.
- States: RUN=0, MDU_WAIT=1, DRAIN=2, HALT=3. Control outputs are combinational from state and inputs; zero-latency.
- RUN: defaults pc_we=1, ifid_we=1, flush=0, bubble=0. Conditions in priority order:
  1. Exit (id_valid & id_exit): pc_we=0, ifid_flush=1; EBREAK advances to EX; next state DRAIN.
  2. Load-use (id_valid & ex_load & ex_rd≠0 & ((use_rs1 & rs1==ex_rd) | (use_rs2 & rs2==ex_rd))): pc_we=0, ifid_we=0, idex_bubble=1; stay in RUN. Lasts exactly 1 cycle because the load moves to MEM and is forwarded. Takes precedence over branch and MDU (e.g. jalr depending on a load).
  3. MDU (id_valid & id_mdu): mdu_start=1 for one cycle, pc_we=0, ifid_we=0, idex_bubble=1; MDU counter cleared; next state MDU_WAIT.
  4. Branch (id_valid & id_branch): pc_we=1, ifid_flush=1, which kills the wrong-path fetch (1-cycle penalty).
  - id_valid=0: all conditions ignored; normal advance.
- MDU_WAIT:
  - Hold with pc_we=0, ifid_we=0, idex_bubble=1; MDU counter +1 per cycle; mdu_start_o=0 (no relaunch while ID still holds the MDU instruction).
  - mdu_done_i=1: pc_we=1, ifid_we=1, bubble=0; the MDU instruction enters EX; next state RUN.
  - Counter reaches MDU_MAX_CYC with no done: err_o=1 (sticky); next state HALT.
  - done and timeout in the same cycle: done wins.
- DRAIN:
  - pc_we=0, ifid_we=0, ifid_flush=1; older instructions continue retiring.
  - wb_valid_i & wb_exit_i: next state HALT.
- HALT:
  - halt_o=1; all other control outputs 0.
  - cycle_cnt_o and stall_cnt_o frozen.
  - Exits only via reset.
- Counters:
  - cycle_cnt_o: +1 every cycle while state≠HALT.
  - instret_o: +1 on wb_valid_i in any state, so the EBREAK retirement is counted.
  - stall_cnt_o: +1 when pc_we_o=0 in RUN or MDU_WAIT.
  - All counters wrap modulo 2^width.

Test Plan:
1. Load x5 in EX, ID add using rs2=x5 -> one cycle with pc_we=0, ifid_we=0, bubble=1; next cycle normal; stall_cnt_o=1.
2. Load to x0 in EX, ID reads x0 -> no stall.
3. ID jalr with rs1 matching a load in EX plus id_branch_i=1 -> cycle 1 stall only (no flush); cycle 2 pc_we=1, ifid_flush=1.
4. ID mul -> mdu_start 1-cycle pulse, state_o=1; mdu_done_i after 5 cycles -> advance, state_o=0; stall_cnt_o=6.
5. MDU with no done, MDU_MAX_CYC=8 -> after 8 MDU_WAIT cycles, err_o=1, state_o=3, halt_o=1; cycle_cnt_o frozen thereafter.
6. ID EBREAK, wb_exit_i 3 cycles later -> DRAIN 3 cycles with ifid_flush=1, then HALT; instret_o includes the EBREAK. Assert rst_n=0 during DRAIN -> state RUN, counters 0.
